// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the clock divider bank.
// Divisor limits and the high-phase length of a period.
package clock_divider_pkg;

  localparam int MIN_DIV = 2;
  localparam int DEFAULT_DIV = 2;

  // High phase is ceil(div/2); written without +1 so it cannot overflow.
  function automatic logic [31:0] high_count(input logic [31:0] div);
    return (div >> 1) + {31'd0, div[0]};
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, pending divisor and boundary swap.
// Outputs are registered so they are glitch-free downstream.
module clock_divider_channel #(
  parameter int WIDTH = 16,
  parameter int DEFAULT_DIV = clock_divider_pkg::DEFAULT_DIV
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic             load_fire,
  input  logic [WIDTH-1:0] load_divisor,
  output logic             pending,
  output logic             div_out,
  output logic             tick
);

  import clock_divider_pkg::*;

  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] pending_div;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] restart_div;
  logic             wrap;
  logic             boundary;
  logic             next_high;

  // Clamp, wrap detection and the divisor a restart would adopt.
  always_comb begin
    clamped = load_divisor;
    if (load_divisor < WIDTH'(MIN_DIV))
      clamped = WIDTH'(MIN_DIV);
    wrap = (count == active_div - WIDTH'(1));
    boundary = enable && wrap;
    next_count = wrap ? '0 : count + WIDTH'(1);
    next_high = 32'(next_count) < high_count(32'(active_div));
    restart_div = active_div;
    if (load_fire)
      restart_div = clamped;
    else if (pending)
      restart_div = pending_div;
  end

  // Counter, outputs and pending-divisor handoff at period boundaries.
  always_ff @(posedge clock) begin
    if (reset) begin
      active_div <= WIDTH'(DEFAULT_DIV);
      count <= WIDTH'(DEFAULT_DIV - 1);
      pending_div <= WIDTH'(DEFAULT_DIV);
      pending <= 1'b0;
      div_out <= 1'b0;
      tick <= 1'b0;
    end else if (restart) begin
      active_div <= restart_div;
      count <= restart_div - WIDTH'(1);
      pending <= 1'b0;
      div_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      if (enable) begin
        count <= next_count;
        div_out <= next_high;
        tick <= (next_count == '0);
      end else begin
        tick <= 1'b0;
      end
      if (boundary && pending) begin
        active_div <= pending_div;
        pending <= 1'b0;
      end
      if (load_fire) begin
        pending_div <= clamped;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers.
// Decodes the shared load port and fans out to each channel.
module clock_divider_bank #(
  parameter int CHANNELS = 2,
  parameter int WIDTH = 16,
  parameter int DEFAULT_DIV = clock_divider_pkg::DEFAULT_DIV,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                restart,
  input  logic                load_valid,
  input  logic [CW-1:0]       load_channel,
  input  logic [WIDTH-1:0]    load_divisor,
  output logic                load_ready,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] tick
);

  import clock_divider_pkg::*;

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] fire;

  // Ready reflects the addressed channel; unknown channels always accept.
  always_comb begin
    load_ready = 1'b1;
    fire = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_channel == CW'(i)) begin
        load_ready = !pending[i];
        fire[i] = load_valid && !pending[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_divider_channel #(
      .WIDTH(WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .restart(restart),
      .load_fire(fire[g]),
      .load_divisor(load_divisor),
      .pending(pending[g]),
      .div_out(div_out[g]),
      .tick(tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank.
// Phase-based reference model predicts outputs per cycle.
module tb_clock_divider_bank;

  localparam int CH = 3;
  localparam int W = 8;
  localparam int DEF = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic restart = 1'b0;
  logic load_valid = 1'b0;
  logic [1:0] load_channel = '0;
  logic [W-1:0] load_divisor = '0;
  logic load_ready;
  logic [CH-1:0] div_out;
  logic [CH-1:0] tick;

  clock_divider_bank #(
    .CHANNELS(CH),
    .WIDTH(W),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .restart(restart),
    .load_valid(load_valid),
    .load_channel(load_channel),
    .load_divisor(load_divisor),
    .load_ready(load_ready),
    .div_out(div_out),
    .tick(tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [CH-1:0] div;
    logic [CH-1:0] tk;
    logic          rdy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Model: period length, position within period, pending divisor.
  int m_d[CH];
  int m_ph[CH];
  int m_pd[CH];
  bit m_pv[CH];
  bit m_out[CH];
  bit m_tk[CH];

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, req);
    end
  endfunction

  task automatic cycle(input bit rst, input bit en, input bit rs,
                       input bit lv, input int lc, input int ld);
    bit acc;
    int cl;
    int nd;
    bit wrapping;
    exp_t e;
    @(negedge clock);
    reset = rst;
    enable = en;
    restart = rs;
    load_valid = lv;
    load_channel = 2'(lc);
    load_divisor = W'(ld);
    acc = 0;
    if (lv && lc < CH) acc = !m_pv[lc];
    cl = (ld < 2) ? 2 : ld;
    for (int i = 0; i < CH; i++) begin
      if (rst) begin
        m_d[i] = DEF;
        m_ph[i] = DEF - 1;
        m_pv[i] = 0;
        m_out[i] = 0;
        m_tk[i] = 0;
      end else if (rs) begin
        nd = m_d[i];
        if (acc && lc == i) nd = cl;
        else if (m_pv[i]) nd = m_pd[i];
        m_d[i] = nd;
        m_ph[i] = nd - 1;
        m_pv[i] = 0;
        m_out[i] = 0;
        m_tk[i] = 0;
      end else begin
        wrapping = en && (m_ph[i] == m_d[i] - 1);
        if (en) begin
          m_ph[i] = (m_ph[i] + 1) % m_d[i];
          m_out[i] = m_ph[i] < (m_d[i] + 1) / 2;
          m_tk[i] = (m_ph[i] == 0);
        end else begin
          m_tk[i] = 0;
        end
        if (wrapping && m_pv[i]) begin
          m_d[i] = m_pd[i];
          m_pv[i] = 0;
        end
        if (acc && lc == i) begin
          m_pv[i] = 1;
          m_pd[i] = cl;
        end
      end
      e.div[i] = m_out[i];
      e.tk[i] = m_tk[i];
    end
    e.rdy = 1'b1;
    if (lc < CH) e.rdy = !m_pv[lc];
    sb.push_back(e);
    started = 1;
  endtask

  // Monitor: compare DUT outputs with queued predictions after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (started) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("div_out", int'(div_out), int'(e.div));
          chk("tick", int'(tick), int'(e.tk));
          chk("load_ready", int'(load_ready), int'(e.rdy));
        end
      end
    end
  end

  initial begin
    int lc;
    int ld;
    repeat (2) cycle(1, 0, 0, 0, 0, 0);
    repeat (8) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 5);
    repeat (14) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 4);
    cycle(0, 1, 0, 1, 0, 3);
    cycle(0, 1, 0, 1, 1, 7);
    repeat (10) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0);
    repeat (6) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 2, 1);
    repeat (6) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 5);
    repeat (7) cycle(0, 1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    repeat (6) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 6);
    cycle(0, 1, 1, 1, 2, 9);
    repeat (12) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 9);
    cycle(1, 1, 0, 0, 0, 0);
    repeat (6) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 3, 7);
    repeat (4) cycle(0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      lc = $urandom_range(0, 3);
      ld = ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 12);
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 9) < 3,
            lc, ld);
    end
    @(posedge clock);
    #2;
    started = 0;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised bank of `CHANNELS` independent synchronous clock dividers, the next generation of the fixed divide-by-two flip-flop divider. Each channel divides `clock` by a runtime-programmable integer `D` (2 .. 2^WIDTH-1), including odd ratios. New divisors load through a valid/ready port and are applied glitch-free at the next period boundary. Outputs feed downstream logic as clock-enable strobes (`tick`) or as divided square waves (`div_out`).

## Interface
- `CHANNELS`, 2: number of independent divider channels (≥1).
- `WIDTH`, 16: divisor and counter width in bits.
- `DEFAULT_DIV`, 2: divisor loaded into every channel at reset (≥2).
- `clock` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: global count enable; when low, all counters and outputs hold.
- `restart` input 1: synchronous realign of all channels (see Operation).
- `load_valid` input 1: divisor load request.
- `load_channel` input $clog2(CHANNELS) (min 1): target channel.
- `load_divisor` input WIDTH: requested divisor.
- `load_ready` output 1: load is accepted this cycle when `load_valid && load_ready`.
- `div_out` output CHANNELS: divided square wave per channel, registered.
- `tick` output CHANNELS: one-cycle pulse, registered, coincident with each `div_out` rising edge.

## Operation
- Per channel state: `active_div`, `count` (WIDTH), `pending_valid`, `pending_div`, `div_out`, `tick`.
- High count `H = (active_div + 1) >> 1`; low count is `active_div - H`. Even D gives 50% duty. Odd D gives one extra high cycle.
- Per enabled cycle: `next = (count == active_div-1) ? 0 : count+1`; `count <= next`; `div_out <= (next < H)`; `tick <= (next == 0)`.
- Boundary: an enabled cycle in which `count == active_div-1`. If `pending_valid` is set, that cycle uses the old divisor for its wrap. Then `active_div <= pending_div` and `pending_valid` clears. The new divisor governs the period starting at `next == 0`.
- Load: `load_ready = !pending_valid[load_channel]`. On acceptance, `pending_div <= max(load_divisor, 2)` and `pending_valid <= 1`. Divisors 0 and 1 are clamped to 2. A load accepted on the same cycle as a boundary is held until the following boundary.
- `enable` low: `count`, `div_out` and `active_div` hold, and `tick` is driven 0. Loads are still accepted into `pending`.
- `restart` (enable-independent, lower priority than `reset`):
  - Any pending divisor is applied immediately.
  - `count <= new active_div - 1`, `div_out <= 0`, `tick <= 0`.
  - A load accepted in the same cycle is applied too.
- Out-of-range `load_channel` (≥ CHANNELS): `load_ready` is 1 and the request is discarded.

## Timing
- Reset values: `active_div = DEFAULT_DIV`, `count = DEFAULT_DIV-1`, `pending_valid = 0`, `div_out = 0`, `tick = 0`, `load_ready = 1`.
- First enabled edge after reset or restart: `div_out` rises and `tick` pulses. Output period is `active_div` enabled cycles.
- D=2 behaviour is cycle-identical to the legacy divider: `div_out` toggles every cycle starting high.
- Load-to-effect latency: the remainder of the current period, at most `active_div` enabled cycles.
- Reset mid-period or mid-pending: everything returns to reset values and the pending divisor is lost.

## Structure
- Package `clock_divider_pkg`: `MIN_DIV = 2`, `DEFAULT_DIV` default, and function `high_count(div)`.
- Sub-module `clock_divider_channel` holds one channel's state, the boundary logic and the clamping. The top level decodes the load port, generates `load_ready`, and instantiates `CHANNELS` copies.

## Test plan
- **Reset then enable:** CHANNELS=2, enable=1. Required: `div_out[0]` = 1,0,1,0… and `tick` on every other cycle starting at the first edge.
- **Odd divisor:** load D=5 on ch1 and wait for the boundary. Required: `div_out[1]` is 3 cycles high, 2 low, and `tick` every 5 cycles.
- **Load during a period:** load D=4 mid-period on ch0, then attempt a second load. Required: the current period completes at D=2 first; `load_ready` is 0 for ch0 until the boundary and 1 for ch1.
- **Clamp:** load 0 and 1. Required: both behave as D=2.
- **enable low for 3 cycles mid-period:** Required: `div_out` holds, `tick` is 0, and the phase resumes exactly.
- **Reset and restart:** `restart` with pending D=6 realigns both channels and the first edge rises. `reset` mid-pending: period reverts to DEFAULT_DIV.
